rx2in_ctl: RTL and testbench

//  Receive-side bridge between the UART receiver (rxuartlite) and the HRM-CPU INBOX.

---
 rtl/rx2in_ctl.sv | 111 +++++++++++
 tb/tb_rx2in_ctl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx2in_ctl.sv
// rx2in_ctl: UART RX byte FIFO draining into the HRM-CPU INBOX.
// Optional RTS flow control when RX2IN_RTS_EN is defined.
module rx2in_ctl #(
  parameter int AW = 4
`ifdef RX2IN_RTS_EN
  ,
  parameter int RTS_MARGIN = 2
`endif
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_wr,
  input  logic [7:0]    i_data,
  input  logic          i_full,
  input  logic          i_clr_ovr,
  output logic          o_push,
  output logic [7:0]    o_data,
  output logic [AW:0]   o_level,
  output logic          o_overrun
`ifdef RX2IN_RTS_EN
  ,
  output logic          o_rts_n
`endif
);

  localparam int DEPTH = 2 ** AW;

  localparam logic [AW:0] C_FULL = {1'b1, {AW{1'b0}}};

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic          r_push;
  logic [7:0]    r_data;
  logic          r_overrun;

  logic          w_pop;
  logic          w_wr_ok;
  logic          w_drop;
  logic [AW:0]   w_level_nxt;

  // Pop/write qualification and next occupancy
  always_comb begin
    w_pop       = (r_level != '0) && !i_full && !r_push;
    w_wr_ok     = i_wr && ((r_level != C_FULL) || w_pop);
    w_drop      = i_wr && !w_wr_ok;
    w_level_nxt = r_level + (AW+1)'(w_wr_ok) - (AW+1)'(w_pop);
  end

  // Byte storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (w_wr_ok)
      r_mem[r_wptr] <= i_data;
  end

  // Pointers, level and INBOX push strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_push  <= 1'b0;
      r_data  <= 8'h00;
    end else begin
      r_level <= w_level_nxt;
      r_push  <= w_pop;
      if (w_wr_ok)
        r_wptr <= r_wptr + AW'(1);
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
        r_data <= r_mem[r_rptr];
      end
    end
  end

  // Sticky overrun; a drop beats a same-edge clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_overrun <= 1'b0;
    else if (w_drop)
      r_overrun <= 1'b1;
    else if (i_clr_ovr)
      r_overrun <= 1'b0;
  end

`ifdef RX2IN_RTS_EN
  localparam logic [AW:0] C_RTS_HI = C_FULL - (AW+1)'(RTS_MARGIN);
  localparam logic [AW:0] C_RTS_LO = C_FULL >> 1;

  logic r_rts_n;

  // RTS with hysteresis between half-full and the margin
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_rts_n <= 1'b1;
    else if (w_level_nxt >= C_RTS_HI)
      r_rts_n <= 1'b1;
    else if (w_level_nxt <= C_RTS_LO)
      r_rts_n <= 1'b0;
  end

  assign o_rts_n = r_rts_n;
`endif

  assign o_push    = r_push;
  assign o_data    = r_data;
  assign o_level   = r_level;
  assign o_overrun = r_overrun;

endmodule

// File: tb/tb_rx2in_ctl.sv
// tb_rx2in_ctl: directed checks of rx2in_ctl.
// Optional RTS checks when RX2IN_RTS_EN is defined.
module tb_rx2in_ctl;

  localparam int AW = 4;

  logic        clk;
  logic        reset_n;
  logic        i_wr;
  logic [7:0]  i_data;
  logic        i_full;
  logic        i_clr_ovr;
  logic        o_push;
  logic [7:0]  o_data;
  logic [AW:0] o_level;
  logic        o_overrun;
`ifdef RX2IN_RTS_EN
  logic        o_rts_n;
`endif

  int n_checks;
  int n_errors;
  logic [7:0] q[$];

  rx2in_ctl #(.AW(AW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_wr      (i_wr),
    .i_data    (i_data),
    .i_full    (i_full),
    .i_clr_ovr (i_clr_ovr),
    .o_push    (o_push),
    .o_data    (o_data),
    .o_level   (o_level),
    .o_overrun (o_overrun)
`ifdef RX2IN_RTS_EN
    ,
    .o_rts_n   (o_rts_n)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    i_wr   = 1'b1;
    i_data = d;
    tick();
    i_wr   = 1'b0;
  endtask

  task automatic collect(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (o_push) q.push_back(o_data);
    end
  endtask

  task automatic drain_to(input int lvl);
    int k;
    k = 0;
    i_full = 1'b0;
    while (int'(o_level) != lvl && k < 100) begin
      tick();
      k++;
    end
    i_full = 1'b1;
    chk("drain_timeout", 32'(k < 100), 32'd1);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #3;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset_n   = 1'b0;
    i_wr      = 1'b0;
    i_data    = 8'h00;
    i_full    = 1'b0;
    i_clr_ovr = 1'b0;
    #12;
    chk("rst_push", 32'(o_push), 32'd0);
    chk("rst_data", 32'(o_data), 32'h00);
    chk("rst_level", 32'(o_level), 32'd0);
    chk("rst_ovr", 32'(o_overrun), 32'd0);
`ifdef RX2IN_RTS_EN
    chk("rst_rts", 32'(o_rts_n), 32'd1);
`endif
    tick();
    reset_n = 1'b1;
    tick();
`ifdef RX2IN_RTS_EN
    chk("rts_after_rst", 32'(o_rts_n), 32'd0);
`endif

    // 1: single byte latency
    wr(8'h41);
    chk("t1_lvl1", 32'(o_level), 32'd1);
    chk("t1_nopush", 32'(o_push), 32'd0);
    tick();
    chk("t1_push", 32'(o_push), 32'd1);
    chk("t1_data", 32'(o_data), 32'h41);
    chk("t1_lvl0", 32'(o_level), 32'd0);
    tick();
    chk("t1_push_end", 32'(o_push), 32'd0);
    chk("t1_hold", 32'(o_data), 32'h41);

    // 2: blocked by full, then ordered drain on alternate cycles
    i_full = 1'b1;
    wr(8'h01);
    wr(8'h02);
    wr(8'h03);
    chk("t2_lvl3", 32'(o_level), 32'd3);
    chk("t2_nopush", 32'(o_push), 32'd0);
    i_full = 1'b0;
    tick();
    chk("t2_p1", 32'(o_push), 32'd1);
    chk("t2_d1", 32'(o_data), 32'h01);
    tick();
    chk("t2_gap1", 32'(o_push), 32'd0);
    tick();
    chk("t2_p2", 32'(o_push), 32'd1);
    chk("t2_d2", 32'(o_data), 32'h02);
    tick();
    chk("t2_gap2", 32'(o_push), 32'd0);
    tick();
    chk("t2_p3", 32'(o_push), 32'd1);
    chk("t2_d3", 32'(o_data), 32'h03);
    chk("t2_lvl0", 32'(o_level), 32'd0);
    tick();
    chk("t2_end", 32'(o_push), 32'd0);

    // 3: overrun on 17th byte, drain 16, clear
    i_full = 1'b1;
    for (int i = 0; i < 17; i++) wr(8'(i));
    chk("t3_lvl16", 32'(o_level), 32'd16);
    chk("t3_ovr", 32'(o_overrun), 32'd1);
    q.delete();
    i_full = 1'b0;
    collect(40);
    chk("t3_count", 32'(q.size()), 32'd16);
    for (int i = 0; i < q.size(); i++)
      chk("t3_order", 32'(q[i]), 32'(i));
    chk("t3_ovr_sticky", 32'(o_overrun), 32'd1);
    i_clr_ovr = 1'b1;
    tick();
    i_clr_ovr = 1'b0;
    chk("t3_ovr_clr", 32'(o_overrun), 32'd0);

    // 4: write at full coinciding with a pop
    i_full = 1'b1;
    for (int i = 0; i < 16; i++) wr(8'(8'h20 + i));
    chk("t4_lvl16", 32'(o_level), 32'd16);
    i_full = 1'b0;
    wr(8'h30);
    chk("t4_push", 32'(o_push), 32'd1);
    chk("t4_data", 32'(o_data), 32'h20);
    chk("t4_lvl", 32'(o_level), 32'd16);
    chk("t4_ovr", 32'(o_overrun), 32'd0);
    q.delete();
    collect(40);
    chk("t4_count", 32'(q.size()), 32'd16);
    for (int i = 0; i < q.size(); i++)
      chk("t4_order", 32'(q[i]), 32'(8'h21 + i));
    chk("t4_lvl0", 32'(o_level), 32'd0);

    // 5: reset mid-drain discards the buffer
    i_full = 1'b1;
    for (int i = 0; i < 6; i++) wr(8'(8'h50 + i));
    i_full = 1'b0;
    tick();
    chk("t5_push", 32'(o_push), 32'd1);
    chk("t5_lvl5", 32'(o_level), 32'd5);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_push", 32'(o_push), 32'd0);
    chk("t5_rst_lvl", 32'(o_level), 32'd0);
    chk("t5_rst_data", 32'(o_data), 32'h00);
    tick();
    reset_n = 1'b1;
    q.delete();
    collect(12);
    chk("t5_nopush", 32'(q.size()), 32'd0);
    chk("t5_lvl", 32'(o_level), 32'd0);

`ifdef RX2IN_RTS_EN
    // 6: RTS hysteresis
    i_full = 1'b1;
    for (int i = 0; i < 13; i++) wr(8'(i));
    chk("t6_rts13", 32'(o_rts_n), 32'd0);
    wr(8'h0d);
    chk("t6_lvl14", 32'(o_level), 32'd14);
    chk("t6_rts14", 32'(o_rts_n), 32'd1);
    drain_to(9);
    chk("t6_rts9", 32'(o_rts_n), 32'd1);
    drain_to(8);
    chk("t6_rts8", 32'(o_rts_n), 32'd0);
    do_reset();
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
